// File: rtl/flt2int_pkg.sv
// Shared types and widths for the float16 -> sign-magnitude integer converter.
package flt2int_pkg;

   localparam int unsigned EXP_W  = 5;
   localparam int unsigned MANT_W = 10;
   localparam int unsigned INT_W  = 16;
   localparam int unsigned CNT_W  = 5;   // holds shift count -10..+4 in two's complement
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [3:0] {
      IDLE,
      ARMED,
      LD_HI,
      LD_LO,
      CLASSIFY,
      SHIFT,
      WR_HI,
      WR_LO,
      DONE
   } state_t;

   // Unpacked fields of a float16 operand as loaded from memory.
   typedef struct packed {
      logic              sgn;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } f16_t;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: asynchronous read, synchronous write, contents not reset.
// Ports: clk; we/wr_addr/wr_data write port; rd_addr/rd_data_c combinational read port.
module data_mem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data_c
);

   logic [7:0] mem_core [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_core[wr_addr] <= wr_data;
      end
   end

   assign rd_data_c = mem_core[rd_addr];

endmodule

// File: rtl/flt2int_seq.sv
// Sequential float16 -> sign-magnitude int16 converter working out of its own data memory.
// Ports: clk; reset (sync, active-high); req (conversion launches on req 1->0);
//        ack (registered done flag, high in DONE until next req rise or reset).
module flt2int_seq
   import flt2int_pkg::*;
#(
   parameter int unsigned IN_ADDR   = 4,
   parameter int unsigned OUT_ADDR  = 6,
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned BIAS      = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic ack
);

   localparam int unsigned AW         = $clog2(MEM_DEPTH);
   localparam int unsigned EXP_SAT    = BIAS + 15;      // first exponent that saturates
   localparam int unsigned SHIFT_ZERO = BIAS + MANT_W;  // exponent needing no shift

   state_t state, state_nxt;

   f16_t               fl;
   logic [INT_W-2:0]   mag;
   logic [CNT_W-1:0]   cnt;   // two's complement; msb set means shift right

   logic               we_c;
   logic [AW-1:0]      rd_addr_c;
   logic [AW-1:0]      wr_addr_c;
   logic [BYTE_W-1:0]  wr_data_c;
   logic [BYTE_W-1:0]  rd_data_c;
   logic               in_range_c;
   logic [CNT_W-1:0]   cnt_init_c;
   logic               last_shift_c;
   logic [INT_W-1:0]   result_c;

   assign in_range_c   = (fl.exp >= EXP_W'(BIAS)) && (fl.exp < EXP_W'(EXP_SAT));
   assign cnt_init_c   = CNT_W'(fl.exp) - CNT_W'(SHIFT_ZERO);
   // This cycle's shift brings cnt to zero (|cnt|==1), or nothing is left to do.
   assign last_shift_c = (cnt == CNT_W'(1)) || (cnt == '1) || (cnt == '0);
   assign result_c     = {fl.sgn, mag};

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and memory port control
   always_comb begin
      state_nxt = state;
      we_c      = 1'b0;
      rd_addr_c = AW'(IN_ADDR);
      wr_addr_c = AW'(OUT_ADDR);
      wr_data_c = result_c[INT_W-1:BYTE_W];
      case (state)
         IDLE:     if (req) state_nxt = ARMED;
         ARMED:    if (!req) state_nxt = LD_HI;
         LD_HI: begin
            rd_addr_c = AW'(IN_ADDR);
            state_nxt = LD_LO;
         end
         LD_LO: begin
            rd_addr_c = AW'(IN_ADDR + 1);
            state_nxt = CLASSIFY;
         end
         CLASSIFY: state_nxt = (in_range_c && (cnt_init_c != '0)) ? SHIFT : WR_HI;
         SHIFT:    if (last_shift_c) state_nxt = WR_HI;
         WR_HI: begin
            we_c      = 1'b1;
            wr_addr_c = AW'(OUT_ADDR);
            wr_data_c = result_c[INT_W-1:BYTE_W];
            state_nxt = WR_LO;
         end
         WR_LO: begin
            we_c      = 1'b1;
            wr_addr_c = AW'(OUT_ADDR + 1);
            wr_data_c = result_c[BYTE_W-1:0];
            state_nxt = DONE;
         end
         DONE:     if (req) state_nxt = ARMED;
         default:  state_nxt = IDLE;
      endcase
   end

   // Datapath: operand load, classification, one-bit-per-cycle shifter, ack flag
   always_ff @(posedge clk) begin
      if (reset) begin
         fl  <= '0;
         mag <= '0;
         cnt <= '0;
         ack <= 1'b0;
      end else begin
         ack <= (state_nxt == DONE);
         case (state)
            LD_HI: begin
               fl.sgn             <= rd_data_c[7];
               fl.exp             <= rd_data_c[6:2];
               fl.mant[MANT_W-1:8] <= rd_data_c[1:0];
            end
            LD_LO: fl.mant[7:0] <= rd_data_c;
            CLASSIFY: begin
               if (fl.exp < EXP_W'(BIAS)) begin
                  mag <= '0;
                  cnt <= '0;
               end else if (fl.exp >= EXP_W'(EXP_SAT)) begin
                  mag <= '1;
                  cnt <= '0;
               end else begin
                  mag <= {4'b0, 1'b1, fl.mant};
                  cnt <= cnt_init_c;
               end
            end
            SHIFT: begin
               if (cnt[CNT_W-1]) begin
                  mag <= {1'b0, mag[INT_W-2:1]};   // truncating right shift
                  cnt <= cnt + CNT_W'(1);
               end else if (cnt != '0) begin
                  mag <= {mag[INT_W-3:0], 1'b0};
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   data_mem #(
      .DEPTH (MEM_DEPTH),
      .AW    (AW)
   ) data_mem1 (
      .clk       (clk),
      .we        (we_c),
      .wr_addr   (wr_addr_c),
      .wr_data   (wr_data_c),
      .rd_addr   (rd_addr_c),
      .rd_data_c (rd_data_c)
   );

endmodule
